// File: rtl/tl_a_if.sv
// A-channel master bundle: command FIFO, write-data FIFO, A channel and status.
interface tl_a_if;
    logic         i_req_valid;
    logic [36:0]  i_req;
    logic         o_req_pop;
    logic [63:0]  i_wdata;
    logic         i_wdata_empty;
    logic         o_wdata_pop;
    logic         m_a_valid;
    logic         m_a_ready;
    logic [100:0] o_header;
    logic         o_busy;
    logic         o_err;

    modport master (
        input  i_req_valid, i_req, i_wdata, i_wdata_empty, m_a_ready,
        output o_req_pop, o_wdata_pop, m_a_valid, o_header, o_busy, o_err
    );

    modport slave (
        output i_req_valid, i_req, i_wdata, i_wdata_empty, m_a_ready,
        input  o_req_pop, o_wdata_pop, m_a_valid, o_header, o_busy, o_err
    );
endinterface

// File: rtl/tl_a_master.sv
// TileLink A-channel master: pops commands, issues PutFullData bursts
// streamed from a write-data FIFO, or single-beat Get requests.
module tl_a_master #(
    parameter int unsigned BAND_WIDTH = 3,
    parameter int unsigned MAX_SIZE   = 6
) (
    input logic     clk,
    input logic     rst,
    tl_a_if.master  bus
);
    localparam int unsigned OP_W   = 3;
    localparam int unsigned SIZE_W = 3;
    localparam int unsigned MARK_W = 4;
    localparam int unsigned ADDR_W = 27;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned BEAT_W = 4;

    localparam logic [OP_W-1:0] OP_PUT = 3'd0;
    localparam logic [OP_W-1:0] OP_GET = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PUT  = 2'd1,
        GET  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [SIZE_W-1:0]   size_q;
    logic [MARK_W-1:0]   mark_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic                err_q, err_d;
    logic                capture;

    logic                req_pop, wdata_pop, a_valid;
    logic [100:0]        header;

    logic [OP_W-1:0]     req_op;
    logic [SIZE_W-1:0]   req_size;
    logic                size_ok;
    logic [BEAT_W:0]     beats;
    logic [BEAT_W-1:0]   last_beat;

    assign req_op   = bus.i_req[36:34];
    assign req_size = bus.i_req[33:31];
    assign size_ok  = 32'(req_size) <= MAX_SIZE;

    // Burst length from the captured size; sub-beat sizes still take one beat.
    always_comb begin
        beats = 5'd1;
        if (32'(size_q) >= BAND_WIDTH)
            beats = 5'(5'd1 << (32'(size_q) - BAND_WIDTH));
        last_beat = 4'(beats - 5'd1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            size_q  <= '0;
            mark_q  <= '0;
            addr_q  <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
            if (capture) begin
                size_q <= req_size;
                mark_q <= bus.i_req[30:27];
                addr_q <= bus.i_req[26:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        err_d     = 1'b0;
        capture   = 1'b0;
        req_pop   = 1'b0;
        wdata_pop = 1'b0;
        a_valid   = 1'b0;
        header    = '0;
        case (state_q)
            IDLE: begin
                // Gate on rst so no pop leaks out while reset is held.
                if (bus.i_req_valid && !rst) begin
                    req_pop = 1'b1;
                    capture = 1'b1;
                    beat_d  = '0;
                    if (req_op == OP_PUT && size_ok)
                        state_d = PUT;
                    else if (req_op == OP_GET && size_ok)
                        state_d = GET;
                    else
                        err_d = 1'b1;
                end
            end
            PUT: begin
                a_valid = !bus.i_wdata_empty;
                if (a_valid) begin
                    header = {OP_PUT, size_q, mark_q, addr_q, bus.i_wdata};
                    if (bus.m_a_ready) begin
                        wdata_pop = 1'b1;
                        beat_d    = beat_q + 4'd1;
                        if (beat_q == last_beat)
                            state_d = IDLE;
                    end
                end
            end
            GET: begin
                a_valid = 1'b1;
                header  = {OP_GET, size_q, mark_q, addr_q, DATA_W'(0)};
                if (bus.m_a_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.o_req_pop   = req_pop;
    assign bus.o_wdata_pop = wdata_pop;
    assign bus.m_a_valid   = a_valid;
    assign bus.o_header    = header;
    assign bus.o_busy      = state_q != IDLE;
    assign bus.o_err       = err_q;

endmodule

// File: tb/tb_tl_a_master.sv
// Directed bench for tl_a_master: PUT bursts, GET with backpressure,
// data-starved PUT, rejected commands, mid-burst reset, sub-beat PUT.
module tb_tl_a_master;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   fires  = 0;
    int   pops   = 0;
    int   f0, p0;

    tl_a_if bus ();

    tl_a_master #(.BAND_WIDTH(3), .MAX_SIZE(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst) begin
            if (bus.m_a_valid && bus.m_a_ready) fires = fires + 1;
            if (bus.o_wdata_pop) pops = pops + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [36:0] cmd(input logic [2:0] op, input logic [2:0] sz,
                                        input logic [3:0] mk, input logic [26:0] ad);
        return {op, sz, mk, ad};
    endfunction

    function automatic logic [100:0] hdr(input logic [2:0] op, input logic [2:0] sz,
                                         input logic [3:0] mk, input logic [26:0] ad,
                                         input logic [63:0] d);
        return {op, sz, mk, ad, d};
    endfunction

    initial begin
        rst               = 1'b1;
        bus.i_req_valid   = 1'b1;
        bus.i_req         = cmd(3'd0, 3'd3, 4'd1, 27'h10);
        bus.i_wdata       = 64'h0;
        bus.i_wdata_empty = 1'b1;
        bus.m_a_ready     = 1'b0;
        cyc(); cyc();
        #1;
        chk("rst_valid", 128'(bus.m_a_valid), 128'(0));
        chk("rst_pop",   128'(bus.o_req_pop), 128'(0));
        chk("rst_wpop",  128'(bus.o_wdata_pop), 128'(0));
        chk("rst_busy",  128'(bus.o_busy), 128'(0));
        chk("rst_err",   128'(bus.o_err), 128'(0));
        chk("rst_hdr",   128'(bus.o_header), 128'(0));

        bus.i_req_valid = 1'b0;
        rst = 1'b0;
        cyc();

        // PUT size 6: eight back-to-back beats; a GET waits in the FIFO throughout
        f0 = fires; p0 = pops;
        bus.i_req_valid   = 1'b1;
        bus.i_req         = cmd(3'd0, 3'd6, 4'd3, 27'h100);
        bus.i_wdata_empty = 1'b0;
        bus.i_wdata       = 64'hA0;
        bus.m_a_ready     = 1'b1;
        #1;
        chk("put_pop",    128'(bus.o_req_pop), 128'(1));
        chk("put_nvalid", 128'(bus.m_a_valid), 128'(0));
        cyc();
        bus.i_req = cmd(3'd4, 3'd5, 4'd7, 27'h40);
        for (int b = 0; b < 8; b++) begin
            bus.i_wdata = 64'hA0 + 64'(b);
            #1;
            chk("put_valid", 128'(bus.m_a_valid), 128'(1));
            chk("put_hdr",   128'(bus.o_header),
                128'(hdr(3'd0, 3'd6, 4'd3, 27'h100, 64'hA0 + 64'(b))));
            chk("put_wpop",  128'(bus.o_wdata_pop), 128'(1));
            chk("put_nopop", 128'(bus.o_req_pop), 128'(0));
            chk("put_busy",  128'(bus.o_busy), 128'(1));
            cyc();
        end
        #1;
        chk("put_fires",  128'(fires - f0), 128'(8));
        chk("put_pops",   128'(pops - p0), 128'(8));
        chk("put_done",   128'(bus.o_busy), 128'(0));
        chk("idle_hdr",   128'(bus.o_header), 128'(0));
        // One IDLE bubble, then the waiting GET is accepted
        chk("get_pop",    128'(bus.o_req_pop), 128'(1));
        chk("get_nvalid", 128'(bus.m_a_valid), 128'(0));
        cyc();

        // GET size 5 with three cycles of backpressure
        f0 = fires; p0 = pops;
        bus.i_req_valid = 1'b0;
        bus.m_a_ready   = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) bus.m_a_ready = 1'b1;
            #1;
            chk("get_valid", 128'(bus.m_a_valid), 128'(1));
            chk("get_hdr",   128'(bus.o_header),
                128'(hdr(3'd4, 3'd5, 4'd7, 27'h40, 64'd0)));
            chk("get_wpop",  128'(bus.o_wdata_pop), 128'(0));
            cyc();
        end
        #1;
        chk("get_fires", 128'(fires - f0), 128'(1));
        chk("get_pops",  128'(pops - p0), 128'(0));
        chk("get_done",  128'(bus.o_busy), 128'(0));

        // PUT size 4: two beats with the data FIFO empty between them
        f0 = fires;
        bus.i_req_valid   = 1'b1;
        bus.i_req         = cmd(3'd0, 3'd4, 4'd1, 27'h20);
        bus.i_wdata_empty = 1'b1;
        #1;
        chk("p2_pop", 128'(bus.o_req_pop), 128'(1));
        cyc();
        bus.i_req_valid   = 1'b0;
        bus.i_wdata_empty = 1'b0;
        bus.i_wdata       = 64'hB0;
        #1;
        chk("p2_b0_valid", 128'(bus.m_a_valid), 128'(1));
        chk("p2_b0_hdr",   128'(bus.o_header), 128'(hdr(3'd0, 3'd4, 4'd1, 27'h20, 64'hB0)));
        cyc();
        bus.i_wdata_empty = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk("p2_gap_valid", 128'(bus.m_a_valid), 128'(0));
            chk("p2_gap_hdr",   128'(bus.o_header), 128'(0));
            chk("p2_gap_wpop",  128'(bus.o_wdata_pop), 128'(0));
            chk("p2_gap_busy",  128'(bus.o_busy), 128'(1));
            cyc();
        end
        bus.i_wdata_empty = 1'b0;
        bus.i_wdata       = 64'hB1;
        #1;
        chk("p2_b1_valid", 128'(bus.m_a_valid), 128'(1));
        chk("p2_b1_hdr",   128'(bus.o_header), 128'(hdr(3'd0, 3'd4, 4'd1, 27'h20, 64'hB1)));
        cyc();
        #1;
        chk("p2_fires", 128'(fires - f0), 128'(2));
        chk("p2_done",  128'(bus.o_busy), 128'(0));

        // Rejected: opcode 2, then opcode 0 with size 7
        for (int k = 0; k < 2; k++) begin
            bus.i_req_valid = 1'b1;
            bus.i_req = (k == 0) ? cmd(3'd2, 3'd3, 4'd2, 27'h8) : cmd(3'd0, 3'd7, 4'd2, 27'h8);
            #1;
            chk("rej_pop",   128'(bus.o_req_pop), 128'(1));
            chk("rej_noerr", 128'(bus.o_err), 128'(0));
            cyc();
            bus.i_req_valid = 1'b0;
            #1;
            chk("rej_err",   128'(bus.o_err), 128'(1));
            chk("rej_valid", 128'(bus.m_a_valid), 128'(0));
            chk("rej_busy",  128'(bus.o_busy), 128'(0));
            cyc();
            #1;
            chk("rej_errclr", 128'(bus.o_err), 128'(0));
            chk("rej_valid2", 128'(bus.m_a_valid), 128'(0));
        end

        // PUT size 6 abandoned by reset after three beats
        p0 = pops;
        bus.i_req_valid = 1'b1;
        bus.i_req       = cmd(3'd0, 3'd6, 4'd5, 27'h200);
        cyc();
        bus.i_req_valid = 1'b0;
        cyc(); cyc(); cyc();
        chk("rst3_pops", 128'(pops - p0), 128'(3));
        bus.i_req_valid = 1'b1;
        bus.i_req       = cmd(3'd4, 3'd3, 4'd6, 27'h80);
        rst = 1'b1;
        #1;
        chk("rst3_valid", 128'(bus.m_a_valid), 128'(0));
        chk("rst3_wpop",  128'(bus.o_wdata_pop), 128'(0));
        chk("rst3_pop",   128'(bus.o_req_pop), 128'(0));
        chk("rst3_busy",  128'(bus.o_busy), 128'(0));
        chk("rst3_hdr",   128'(bus.o_header), 128'(0));
        cyc();
        rst = 1'b0;
        f0 = fires;
        #1;
        chk("rst3_pops_after", 128'(pops - p0), 128'(3));
        chk("rst3_get_pop", 128'(bus.o_req_pop), 128'(1));
        cyc();
        bus.i_req_valid = 1'b0;
        #1;
        chk("rst3_get_valid", 128'(bus.m_a_valid), 128'(1));
        chk("rst3_get_hdr",   128'(bus.o_header), 128'(hdr(3'd4, 3'd3, 4'd6, 27'h80, 64'd0)));
        cyc();
        #1;
        chk("rst3_get_fires", 128'(fires - f0), 128'(1));
        chk("rst3_get_done",  128'(bus.o_busy), 128'(0));

        // PUT size 2 is below one beat width: single beat
        f0 = fires;
        bus.i_req_valid = 1'b1;
        bus.i_req       = cmd(3'd0, 3'd2, 4'd9, 27'h4);
        bus.i_wdata     = 64'hC0;
        cyc();
        bus.i_req_valid = 1'b0;
        #1;
        chk("p1_valid", 128'(bus.m_a_valid), 128'(1));
        chk("p1_hdr",   128'(bus.o_header), 128'(hdr(3'd0, 3'd2, 4'd9, 27'h4, 64'hC0)));
        cyc();
        #1;
        chk("p1_fires", 128'(fires - f0), 128'(1));
        chk("p1_done",  128'(bus.o_busy), 128'(0));
        chk("p1_valid0", 128'(bus.m_a_valid), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/tl_a_master.md
TL_A_MASTER -- requirements
Module: tl_a_master

Interface
REQ-001 Parameter BAND_WIDTH, default 3, log2 of bytes per A-channel beat.
REQ-002 Parameter MAX_SIZE, default 6, largest legal log2 transfer size.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 i_req_valid  input  1  command FIFO not empty.
REQ-006 i_req  input  37  command {opcode[36:34], size[33:31], mark[30:27], address[26:0]}; show-ahead.
REQ-007 o_req_pop  output  1  one-cycle pop of command FIFO.
REQ-008 i_wdata  input  64  write-data FIFO head word; show-ahead.
REQ-009 i_wdata_empty  input  1  write-data FIFO empty.
REQ-010 o_wdata_pop  output  1  pop of write-data FIFO.
REQ-011 m_a_valid  output  1  A-channel valid.
REQ-012 m_a_ready  input  1  A-channel ready from slave.
REQ-013 o_header  output  101  {opcode[100:98], size[97:95], mark[94:91], address[90:64], data[63:0]}.
REQ-014 o_busy  output  1  high whenever state is not IDLE.
REQ-015 o_err  output  1  one-cycle pulse on a rejected command.

Function
REQ-016 The FSM SHALL have states IDLE, PUT, GET, encoded in 2 bits.
REQ-017 IDLE with i_req_valid=1 SHALL capture i_req into internal registers, assert o_req_pop combinationally that cycle, and clear the beat counter.
REQ-018 Opcode 0 with size<=MAX_SIZE SHALL go to PUT; opcode 4 with size<=MAX_SIZE SHALL go to GET.
REQ-019 Any other opcode, or size>MAX_SIZE, SHALL still be popped, SHALL assert o_err the next cycle, and SHALL return to IDLE; nothing is driven on the A channel.
REQ-020 Beat count (4-bit) SHALL be 1<<(size-BAND_WIDTH) when size>=BAND_WIDTH, else 1, computed from the captured size.
REQ-021 Acceptance latency: a command popped in cycle N SHALL give earliest m_a_valid=1 in cycle N+1.
REQ-022 PUT: m_a_valid SHALL equal !i_wdata_empty.
REQ-023 PUT: o_header SHALL be {3'd0, size, mark, address, i_wdata}.
REQ-024 PUT: fire = m_a_valid & m_a_ready; o_wdata_pop SHALL equal fire; the beat counter SHALL increment on fire.
REQ-025 PUT: address and mark SHALL be held constant for all beats; the slave derives the beat offset.
REQ-026 PUT: fire on beat count-1 (last beat) SHALL go to IDLE.
REQ-027 GET: m_a_valid SHALL be 1; o_header SHALL be {3'd4, size, mark, address, 64'd0}; one beat only; fire SHALL go to IDLE; o_wdata_pop SHALL stay 0.
REQ-028 Once m_a_valid=1, it and o_header SHALL remain stable until fire.
REQ-029 m_a_ready while m_a_valid=0 SHALL be ignored.
REQ-030 When m_a_valid=0, o_header SHALL be 101'd0.
REQ-031 o_req_pop SHALL never assert outside IDLE; a command present on the last-beat fire SHALL be accepted the following cycle (one IDLE bubble).
REQ-032 i_req_valid toggling during PUT/GET SHALL have no effect.

Reset
REQ-033 rst=1 SHALL force IDLE, clear counter and captured command, and drive m_a_valid, o_req_pop, o_wdata_pop, o_busy, o_err to 0 and o_header to 0.
REQ-034 Reset mid-burst SHALL abandon the burst with no further pops; operation resumes from IDLE after rst deasserts.

Verification
REQ-035 PUT size=6, addr=0x100, mark=0x3, 8 words queued, ready always 1 -> 8 consecutive fires in cycles N+1..N+8, opcode 0 each beat, 8 wdata pops, o_busy low at N+9.
REQ-036 GET size=5, addr=0x40, ready low 3 cycles then high -> m_a_valid held 4 cycles with header {4,5,mark,0x40,0}; single fire; zero wdata pops.
REQ-037 PUT size=4 (2 beats), wdata empty for 2 cycles between beats -> m_a_valid drops only while empty; exactly 2 fires.
REQ-038 Opcode 2 command -> o_req_pop=1, o_err pulse next cycle, m_a_valid stays 0; same for opcode 0 with size=7.
REQ-039 rst asserted after beat 3 of 8 -> all outputs 0 immediately; after release, new GET completes normally.
REQ-040 PUT size=2 (<BAND_WIDTH) -> exactly 1 beat.
